// File: rtl/apb_requester_arbiter.sv
// Two-requester round-robin APB arbiter sharing one downstream APB port.
// Define APB_ARB_TIMEOUT_EN to add a watchdog that aborts transactions stuck in ACCESS.
module apb_requester_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    up0_psel,
  input  logic                    up0_penable,
  input  logic                    up0_pwrite,
  input  logic [ADDR_WIDTH-1:0]   up0_paddr,
  input  logic [DATA_WIDTH-1:0]   up0_pwdata,
  input  logic [DATA_WIDTH/8-1:0] up0_pstrb,
  output logic [DATA_WIDTH-1:0]   up0_prdata,
  output logic                    up0_pready,
  output logic                    up0_pslverr,

  input  logic                    up1_psel,
  input  logic                    up1_penable,
  input  logic                    up1_pwrite,
  input  logic [ADDR_WIDTH-1:0]   up1_paddr,
  input  logic [DATA_WIDTH-1:0]   up1_pwdata,
  input  logic [DATA_WIDTH/8-1:0] up1_pstrb,
  output logic [DATA_WIDTH-1:0]   up1_prdata,
  output logic                    up1_pready,
  output logic                    up1_pslverr,

  output logic                    dn_psel,
  output logic                    dn_penable,
  output logic                    dn_pwrite,
  output logic [ADDR_WIDTH-1:0]   dn_paddr,
  output logic [DATA_WIDTH-1:0]   dn_pwdata,
  output logic [DATA_WIDTH/8-1:0] dn_pstrb,
  input  logic [DATA_WIDTH-1:0]   dn_prdata,
  input  logic                    dn_pready,
  input  logic                    dn_pslverr,

  output logic [1:0]              grant,
  output logic                    timeout
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state;
  logic                    last_grant;

  logic                    any_req;
  logic                    pick1;
  logic                    sel_pwrite;
  logic [ADDR_WIDTH-1:0]   sel_paddr;
  logic [DATA_WIDTH-1:0]   sel_pwdata;
  logic [STRB_WIDTH-1:0]   sel_pstrb;

  logic                    acc_abort;
  logic                    acc_done;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  // The arbiter moves on psel alone; penable carries no information it needs.
  logic                    unused_penable;
  assign unused_penable = up0_penable ^ up1_penable;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int                   CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [CNT_WIDTH-1:0]            access_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Port 1 wins only when it is alone or when port 0 was served last.
  always_comb begin
    any_req    = up0_psel | up1_psel;
    pick1      = up1_psel & (~up0_psel | ~last_grant);
    sel_pwrite = pick1 ? up1_pwrite : up0_pwrite;
    sel_paddr  = pick1 ? up1_paddr  : up0_paddr;
    sel_pwdata = pick1 ? up1_pwdata : up0_pwdata;
    sel_pstrb  = pick1 ? up1_pstrb  : up0_pstrb;
  end

  // A completer response in the expiry cycle beats the watchdog abort.
  always_comb begin
    acc_abort = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    acc_abort = ~dn_pready & (access_cnt == CNT_LAST);
`endif
    acc_done   = dn_pready | acc_abort;
    resp_rdata = dn_pready ? dn_prdata  : '0;
    resp_err   = dn_pready ? dn_pslverr : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= '0;
      dn_psel     <= 1'b0;
      dn_penable  <= 1'b0;
      dn_pwrite   <= 1'b0;
      dn_paddr    <= '0;
      dn_pwdata   <= '0;
      dn_pstrb    <= '0;
      up0_prdata  <= '0;
      up0_pready  <= 1'b0;
      up0_pslverr <= 1'b0;
      up1_prdata  <= '0;
      up1_pready  <= 1'b0;
      up1_pslverr <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      timeout     <= 1'b0;
      access_cnt  <= '0;
`endif
    end else begin
`ifdef APB_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            dn_psel    <= 1'b1;
            dn_penable <= 1'b0;
            dn_pwrite  <= sel_pwrite;
            dn_paddr   <= sel_paddr;
            dn_pwdata  <= sel_pwdata;
            dn_pstrb   <= sel_pstrb;
            grant      <= pick1 ? 2'b10 : 2'b01;
            last_grant <= pick1;
            state      <= SETUP;
          end
        end

        SETUP: begin
          dn_penable <= 1'b1;
          state      <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          access_cnt <= '0;
`endif
        end

        ACCESS: begin
          if (acc_done) begin
            dn_psel    <= 1'b0;
            dn_penable <= 1'b0;
            state      <= RESP;
            if (grant[1]) begin
              up1_pready  <= 1'b1;
              up1_prdata  <= resp_rdata;
              up1_pslverr <= resp_err;
            end else begin
              up0_pready  <= 1'b1;
              up0_prdata  <= resp_rdata;
              up0_pslverr <= resp_err;
            end
`ifdef APB_ARB_TIMEOUT_EN
            timeout <= acc_abort;
          end else begin
            access_cnt <= access_cnt + CNT_WIDTH'(1);
`endif
          end
        end

        RESP: begin
          up0_pready  <= 1'b0;
          up0_prdata  <= '0;
          up0_pslverr <= 1'b0;
          up1_pready  <= 1'b0;
          up1_prdata  <= '0;
          up1_pslverr <= 1'b0;
          grant       <= '0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Directed scoreboard bench for apb_requester_arbiter: latency, round-robin order,
// wait states with errors, watchdog (when APB_ARB_TIMEOUT_EN is set), reset mid-transfer, throughput.
module tb_apb_requester_arbiter;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          up0_psel, up0_penable, up0_pwrite;
  logic [AW-1:0] up0_paddr;
  logic [DW-1:0] up0_pwdata;
  logic [SW-1:0] up0_pstrb;
  logic [DW-1:0] up0_prdata;
  logic          up0_pready, up0_pslverr;
  logic          up1_psel, up1_penable, up1_pwrite;
  logic [AW-1:0] up1_paddr;
  logic [DW-1:0] up1_pwdata;
  logic [SW-1:0] up1_pstrb;
  logic [DW-1:0] up1_prdata;
  logic          up1_pready, up1_pslverr;
  logic          dn_psel, dn_penable, dn_pwrite;
  logic [AW-1:0] dn_paddr;
  logic [DW-1:0] dn_pwdata;
  logic [SW-1:0] dn_pstrb;
  logic [DW-1:0] dn_prdata;
  logic          dn_pready, dn_pslverr;
  logic [1:0]    grant;
  logic          timeout;

  apb_requester_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .up0_psel(up0_psel), .up0_penable(up0_penable), .up0_pwrite(up0_pwrite),
    .up0_paddr(up0_paddr), .up0_pwdata(up0_pwdata), .up0_pstrb(up0_pstrb),
    .up0_prdata(up0_prdata), .up0_pready(up0_pready), .up0_pslverr(up0_pslverr),
    .up1_psel(up1_psel), .up1_penable(up1_penable), .up1_pwrite(up1_pwrite),
    .up1_paddr(up1_paddr), .up1_pwdata(up1_pwdata), .up1_pstrb(up1_pstrb),
    .up1_prdata(up1_prdata), .up1_pready(up1_pready), .up1_pslverr(up1_pslverr),
    .dn_psel(dn_psel), .dn_penable(dn_penable), .dn_pwrite(dn_pwrite),
    .dn_paddr(dn_paddr), .dn_pwdata(dn_pwdata), .dn_pstrb(dn_pstrb),
    .dn_prdata(dn_prdata), .dn_pready(dn_pready), .dn_pslverr(dn_pslverr),
    .grant(grant), .timeout(timeout)
  );

  typedef struct {
    int            port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } dn_exp_t;

  typedef struct {
    int            port;
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } up_exp_t;

  dn_exp_t exp_dn[$];
  up_exp_t exp_up[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int            wait_states = 0;
  logic          hang        = 1'b0;
  logic          err_mode    = 1'b0;
  logic [DW-1:0] rd_base     = 32'h0;

  logic any_out;
  assign any_out = |{up0_prdata, up0_pready, up0_pslverr, up1_prdata, up1_pready, up1_pslverr,
                     dn_psel, dn_penable, dn_pwrite, dn_paddr, dn_pwdata, dn_pstrb, grant, timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL global_time_limit observed=expired expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic driveReq(input int port, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
    if (port == 0) begin
      up0_psel = 1'b1; up0_penable = 1'b0; up0_pwrite = wr;
      up0_paddr = addr; up0_pwdata = wdata; up0_pstrb = strb;
    end else begin
      up1_psel = 1'b1; up1_penable = 1'b0; up1_pwrite = wr;
      up1_paddr = addr; up1_pwdata = wdata; up1_pstrb = strb;
    end
  endtask

  task automatic expectTxn(input int port, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input logic [DW-1:0] rdata, input logic err, input logic to);
    dn_exp_t d;
    up_exp_t u;
    d.port = port; d.wr = wr; d.addr = addr; d.wdata = wdata; d.strb = strb;
    u.port = port; u.rdata = rdata; u.err = err; u.to = to;
    exp_dn.push_back(d);
    exp_up.push_back(u);
  endtask

  // Drive a request and queue the response the completer model will produce for it.
  task automatic applyStimulus(input int port, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
    driveReq(port, wr, addr, wdata, strb);
    expectTxn(port, wr, addr, wdata, strb, rd_base ^ DW'(addr), err_mode, 1'b0);
  endtask

  task automatic dropReq(input int port);
    if (port == 0) up0_psel = 1'b0;
    else           up1_psel = 1'b0;
  endtask

  task automatic waitResp(input int port, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if ((port == 0 && up0_pready) || (port == 1 && up1_pready)) seen = 1'b1;
    end
    checkOutput(tag, seen, 1'b1);
    dropReq(port);
  endtask

  // Completer: answers after wait_states ACCESS cycles, never while hang is set.
  initial begin
    int acc;
    acc = 0;
    dn_pready = 1'b0; dn_prdata = '0; dn_pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (dn_psel && dn_penable) begin
        acc++;
        if (!hang && acc > wait_states) begin
          dn_pready = 1'b1; dn_prdata = rd_base ^ DW'(dn_paddr); dn_pslverr = err_mode;
        end else begin
          dn_pready = 1'b0; dn_prdata = '0; dn_pslverr = 1'b0;
        end
      end else begin
        acc = 0;
        dn_pready = 1'b0; dn_prdata = '0; dn_pslverr = 1'b0;
      end
    end
  end

  // Scoreboard: every SETUP cycle and every upstream pready pulse consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (dn_psel && !dn_penable) begin
        if (exp_dn.size() == 0) begin
          checkOutput("dn_unexpected_setup", dn_psel, 1'b0);
        end else begin
          dn_exp_t d;
          d = exp_dn.pop_front();
          checkOutput("dn_grant", grant, (d.port == 0) ? 2'b01 : 2'b10);
          checkOutput("dn_pwrite", dn_pwrite, d.wr);
          checkOutput("dn_paddr", dn_paddr, d.addr);
          checkOutput("dn_pwdata", dn_pwdata, d.wdata);
          checkOutput("dn_pstrb", dn_pstrb, d.strb);
        end
      end
      if (up0_pready || up1_pready) begin
        if (exp_up.size() == 0) begin
          checkOutput("up_unexpected_pready", {up1_pready, up0_pready}, 2'b00);
        end else begin
          up_exp_t u;
          u = exp_up.pop_front();
          checkOutput("up_pready_port", {up1_pready, up0_pready}, (u.port == 0) ? 2'b01 : 2'b10);
          checkOutput("up_timeout", timeout, u.to);
          if (u.port == 0) begin
            checkOutput("up0_prdata", up0_prdata, u.rdata);
            checkOutput("up0_pslverr", up0_pslverr, u.err);
            checkOutput("up1_idle_outs", {up1_prdata, up1_pslverr}, '0);
          end else begin
            checkOutput("up1_prdata", up1_prdata, u.rdata);
            checkOutput("up1_pslverr", up1_pslverr, u.err);
            checkOutput("up0_idle_outs", {up0_prdata, up0_pslverr}, '0);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int pen;
    int setup_cyc[2];
    int k;
    int pulses;
    logic seen;

    rst = 1'b1;
    up0_psel = 0; up0_penable = 0; up0_pwrite = 0; up0_paddr = '0; up0_pwdata = '0; up0_pstrb = '0;
    up1_psel = 0; up1_penable = 0; up1_pwrite = 0; up1_paddr = '0; up1_pwdata = '0; up1_pstrb = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", any_out, 1'b0);
    rst = 1'b0;

    // Zero-wait read from port 0: dn_psel +1, dn_penable +2, pready +3.
    $display("[TB] port 0 zero-wait read latency");
    rd_base = 32'hDEADBAEF;
    @(negedge clk);
    applyStimulus(0, 1'b0, 24'h000400, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t1_setup_psel_penable", {dn_psel, dn_penable}, 2'b10);
    checkOutput("t1_setup_grant", grant, 2'b01);
    @(negedge clk);
    checkOutput("t1_access_psel_penable", {dn_psel, dn_penable}, 2'b11);
    @(negedge clk);
    checkOutput("t1_resp_pready", up0_pready, 1'b1);
    checkOutput("t1_resp_prdata", up0_prdata, 32'hDEADBEEF);
    checkOutput("t1_resp_grant", grant, 2'b01);
    dropReq(0);
    @(negedge clk);
    checkOutput("t1_after_pready", up0_pready, 1'b0);
    checkOutput("t1_after_prdata", up0_prdata, 32'h0);
    checkOutput("t1_after_grant", grant, 2'b00);

    // Both ports request continuously from reset: order 0,1,0,1.
    $display("[TB] continuous dual requests");
    rd_base = 32'h5A5A0000;
    rst = 1'b1;
    @(negedge clk);
    driveReq(0, 1'b1, 24'h000010, 32'h11, 4'hF);
    driveReq(1, 1'b1, 24'h000020, 32'h22, 4'hF);
    for (int r = 0; r < 2; r++) begin
      expectTxn(0, 1'b1, 24'h000010, 32'h11, 4'hF, rd_base ^ 32'h10, 1'b0, 1'b0);
      expectTxn(1, 1'b1, 24'h000020, 32'h22, 4'hF, rd_base ^ 32'h20, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (up0_pready || up1_pready) n++;
    end
    dropReq(0);
    dropReq(1);
    checkOutput("t2_pulse_count", n, 4);
    repeat (6) @(negedge clk);
    checkOutput("t2_queues_drained", exp_dn.size() + exp_up.size(), 0);

    // Port 1 write, five stall cycles then slverr.
    $display("[TB] port 1 write with wait states and error");
    wait_states = 5;
    err_mode = 1'b1;
    @(negedge clk);
    applyStimulus(1, 1'b1, 24'h000300, 32'hCAFEF00D, 4'hF);
    pen = 0;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (dn_penable) pen++;
      if (up1_pready) begin
        seen = 1'b1;
        checkOutput("t3_up0_quiet", {up0_pready, up0_prdata, up0_pslverr}, '0);
      end
    end
    checkOutput("t3_resp_seen", seen, 1'b1);
    checkOutput("t3_penable_cycles", pen, 6);
    dropReq(1);
    wait_states = 0;
    err_mode = 1'b0;
    repeat (2) @(negedge clk);

`ifdef APB_ARB_TIMEOUT_EN
    // Completer never ready: abort after 16 ACCESS cycles with slverr and zero data.
    $display("[TB] watchdog abort");
    hang = 1'b1;
    @(negedge clk);
    driveReq(1, 1'b0, 24'h000500, 32'h0, 4'h0);
    expectTxn(1, 1'b0, 24'h000500, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    pen = 0;
    pulses = 0;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (dn_penable) pen++;
      if (timeout) pulses++;
      if (up1_pready) seen = 1'b1;
    end
    dropReq(1);
    hang = 1'b0;
    checkOutput("t4_abort_seen", seen, 1'b1);
    checkOutput("t4_access_cycles", pen, 16);
    @(negedge clk);
    if (timeout) pulses++;
    checkOutput("t4_timeout_pulse_len", pulses, 1);
    applyStimulus(0, 1'b0, 24'h000600, 32'h0, 4'h0);
    waitResp(0, "t4_recovery_resp");
    @(negedge clk);
`endif

    // Reset during ACCESS of a port 0 read: no pready, last_grant back to port 1.
    $display("[TB] reset mid-transaction");
    hang = 1'b1;
    @(negedge clk);
    driveReq(0, 1'b0, 24'h000700, 32'h0, 4'h0);
    exp_dn.push_back('{port: 0, wr: 1'b0, addr: 24'h000700, wdata: 32'h0, strb: 4'h0});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dn_penable) seen = 1'b1;
    end
    checkOutput("t5_reached_access", seen, 1'b1);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (up0_pready || timeout) pulses++;
    end
    checkOutput("t5_stalled_no_resp", pulses, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_reset_outputs", any_out, 1'b0);
    hang = 1'b0;
    rd_base = 32'h13570000;
    driveReq(0, 1'b0, 24'h000800, 32'h0, 4'h0);
    driveReq(1, 1'b0, 24'h000900, 32'h0, 4'h0);
    expectTxn(0, 1'b0, 24'h000800, 32'h0, 4'h0, rd_base ^ 32'h800, 1'b0, 1'b0);
    expectTxn(1, 1'b0, 24'h000900, 32'h0, 4'h0, rd_base ^ 32'h900, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    waitResp(0, "t5_port0_after_reset");
    waitResp(1, "t5_port1_after_reset");
    repeat (2) @(negedge clk);

    // Back-to-back port 0 reads: SETUP cycles four clocks apart.
    $display("[TB] back-to-back throughput");
    rd_base = 32'h24680000;
    @(negedge clk);
    applyStimulus(0, 1'b0, 24'h000A00, 32'h0, 4'h0);
    expectTxn(0, 1'b0, 24'h000B00, 32'h0, 4'h0, rd_base ^ 32'hB00, 1'b0, 1'b0);
    k = 0;
    n = 0;
    setup_cyc[0] = 0;
    setup_cyc[1] = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      @(negedge clk);
      if (dn_psel && !dn_penable && k < 2) begin
        setup_cyc[k] = cyc;
        k++;
      end
      if (up0_pready) begin
        n++;
        if (n == 1) up0_paddr = 24'h000B00;
      end
    end
    dropReq(0);
    checkOutput("t6_resp_count", n, 2);
    checkOutput("t6_setup_spacing", setup_cyc[1] - setup_cyc[0], 4);
    repeat (3) @(negedge clk);
    checkOutput("final_queues_drained", exp_dn.size() + exp_up.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
